// File: rtl/fmult_pkg.sv
// Shared definitions for the iterative floating-point arithmetic units.
package fmult_pkg;
  typedef enum logic [1:0] {IDLE, MULT, NORM} state_t;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam int          MANT_W  = 24;
  localparam int          STEPS   = 24;

  // Hidden bit restored for normal numbers; denormals are flushed to zero.
  function automatic logic [MANT_W-1:0] mant_of(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? '0 : {1'b1, x[22:0]};
  endfunction
endpackage

// File: rtl/fmult_shift_add.sv
// Radix-2 shift-add mantissa multiplier: one partial product per step.
module fmult_shift_add
  import fmult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [MANT_W-1:0]     mcand_in,
  input  logic [MANT_W-1:0]     mplier_in,
  output logic [2*MANT_W-1:0]   prod,
  output logic                  last_step
);
  logic [MANT_W-1:0]   mcand;
  logic [MANT_W-1:0]   mplier;
  logic [2*MANT_W-1:0] acc;
  logic [4:0]          cnt;
  logic [MANT_W:0]     sum;

  // Carry out of the upper half is shifted back in as the new MSB.
  always_comb begin
    sum = {1'b0, acc[2*MANT_W-1:MANT_W]};
    if (mplier[0]) sum = {1'b0, acc[2*MANT_W-1:MANT_W]} + {1'b0, mcand};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= {sum, acc[MANT_W-1:1]};
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
    end
  end

  assign prod      = acc;
  assign last_step = (cnt == 5'(STEPS - 1));
endmodule

// File: rtl/fmult_iter.sv
// Iterative IEEE-754 single-precision multiplier, fixed 25-cycle latency.
module fmult_iter
  import fmult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  state_t                state, state_next;
  logic [31:0]           a_q, b_q;
  logic                  load, step, last_step;
  logic [2*MANT_W-1:0]   prod;
  logic                  sign;
  logic signed [9:0]     exp_sum;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0]           res_next;

  fmult_shift_add u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .mcand_in  (mant_of(a)),
    .mplier_in (mant_of(b)),
    .prod      (prod),
    .last_step (last_step)
  );

  // Normalise on product bit 47, truncate, then clamp to inf or zero.
  function automatic logic [31:0] norm_pack(input logic s, input logic signed [9:0] e,
                                            input logic [2*MANT_W-1:0] p);
    logic signed [9:0] en;
    logic [22:0]       f;
    if (p[47]) begin
      en = e + 10'sd1;
      f  = p[46:24];
    end else begin
      en = e;
      f  = p[45:23];
    end
    if (en >= $signed(10'(EXP_MAX))) return {s, 8'hFF, 23'h0};
    if (en <= 10'sd0)                return {s, 31'h0};
    return {s, en[7:0], f};
  endfunction

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        state_next = MULT;
      end
      MULT: begin
        step = 1'b1;
        if (last_step) state_next = NORM;
      end
      NORM:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sign    = a_q[31] ^ b_q[31];
    exp_sum = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]})
              - $signed(10'(BIAS));
    a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
    b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
    a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
    b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
    a_zero  = (a_q[30:23] == 8'h00);
    b_zero  = (b_q[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      res_next = QNAN;
    else if (a_inf || b_inf)
      res_next = {sign, 8'hFF, 23'h0};
    else if (a_zero || b_zero)
      res_next = {sign, 31'h0};
    else
      res_next = norm_pack(sign, exp_sum, prod);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == NORM);
      if (load) begin
        a_q <= a;
        b_q <= b;
      end
      if (state == NORM) result <= res_next;
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_fmult_iter.sv
// Randomised and directed bench for fmult_iter against a cycle-level reference model.
module tb_fmult_iter;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_en   = 1'b0;

  fmult_iter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference product from the IEEE field rules using plain integer arithmetic.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int          ex, ey, e;
    longint      mx, my, p;
    logic        s;
    logic        xnan, ynan, xinf, yinf, xz, yz;
    logic [22:0] f;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xnan = (ex == 255) && (x[22:0] != 0);
    ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0);
    yinf = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xnan || ynan || (xinf && yz) || (yinf && xz)) return 32'h7FC0_0000;
    if (xinf || yinf) return {s, 8'hFF, 23'h0};
    if (xz || yz) return {s, 31'h0};
    mx = longint'(x[22:0]) + 64'd8388608;
    my = longint'(y[22:0]) + 64'd8388608;
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin
      e = e + 1;
      f = 23'((p >> 24) & 64'h7FFFFF);
    end else begin
      f = 23'((p >> 23) & 64'h7FFFFF);
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), f};
  endfunction

  // Cycle model: an accepted start yields its product exactly 25 edges later.
  int          m_left = 0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_result = '0, m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_result = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_busy = 1'b0; m_result = m_pend;
        end
      end else if (start) begin
        m_pend = ref_mul(a, b); m_left = 25; m_busy = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("busy", {31'h0, busy}, {31'h0, m_busy});
      chk("done", {31'h0, done}, {31'h0, m_done});
      chk("result", result, m_result);
    end
  end

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
    total++;
    if (!ok) $display("FAIL %s: done not seen within 40 cycles", name);
    else pass_cnt++;
  endtask

  task automatic pulse_start(input logic [31:0] x, input logic [31:0] y);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp);
    bit ok;
    pulse_start(x, y);
    wait_done(name, ok);
    if (ok) chk(name, result, exp);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    logic [22:0] f;
    case ($urandom_range(0, 7))
      0: e = 8'd0;
      1: e = 8'd255;
      2: e = 8'd1;
      3: e = 8'd254;
      default: e = 8'($urandom_range(60, 194));
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    chk("model_a", ref_mul(32'h3FC00000, 32'h40000000), 32'h40400000);
    chk("model_b", ref_mul(32'h40400000, 32'hBF000000), 32'hBFC00000);
    chk("model_ovf", ref_mul(32'h7F000000, 32'h7F000000), 32'h7F800000);
    chk("model_nan", ref_mul(32'h7F800000, 32'h00000000), 32'h7FC00000);

    run_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000);
    run_op("mul_3xm0p5", 32'h40400000, 32'hBF000000, 32'hBFC00000);
    run_op("negzero", 32'h80000000, 32'h3F800000, 32'h80000000);
    run_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000);
    run_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000);
    run_op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    run_op("inf_x_neg", 32'h7F800000, 32'hC0000000, 32'hFF800000);

    // Re-pulse mid-operation is ignored; start right after done is accepted.
    pulse_start(32'h3FC00000, 32'h40000000);
    repeat (4) @(negedge clk);
    pulse_start(32'h40400000, 32'hBF000000);
    wait_done("repulse_done", ok);
    if (ok) chk("repulse_ignored", result, 32'h40400000);
    run_op("back_to_back", 32'h40400000, 32'hBF000000, 32'hBFC00000);

    // Abort mid-multiply, then a fresh operation completes normally.
    pulse_start(32'h3FC00000, 32'h40000000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_result", result, 32'h0);
    repeat (30) @(negedge clk);
    run_op("after_abort", 32'h40400000, 32'h40000000, 32'h40C00000);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = rand_fp();
      y = rand_fp();
      pulse_start(x, y);
      wait_done("rand_done", ok);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/fmult_iter.md
FMULT_ITER -- requirements
Module: fmult_iter

Interface
REQ-001: clk  input  1  single clock for all state; every flop updates on its rising edge.
REQ-002: rst  input  1  reset, synchronous and active-high.
REQ-003: start  input  1  request pulse; sampled only while idle.
REQ-004: a  input  32  IEEE-754 single operand A; captured on the accepting edge.
REQ-005: b  input  32  IEEE-754 single operand B; captured on the accepting edge.
REQ-006: busy  output  1  high from the accepting edge until done is asserted.
REQ-007: done  output  1  one-cycle pulse; marks result as valid.
REQ-008: result  output  32  product; holds its value until the next done.

Function
REQ-009: The FSM SHALL have states IDLE, MULT and NORM.
REQ-010: IDLE with start=1 at edge T0 SHALL latch a and b, clear the 48-bit accumulator and the 5-bit step counter, and go to MULT.
REQ-011: While in IDLE, start=0 SHALL hold state and leave result unchanged.
REQ-012: start SHALL be ignored while busy=1; no queuing, and latched operands SHALL NOT change.
REQ-013: Each MULT edge SHALL perform one shift-add step.
- If multiplier LSB is 1, add the 24-bit multiplicand into the upper accumulator half with a 25-bit carry.
- Then shift accumulator and multiplier right by 1, and increment the counter.
REQ-014: MULT SHALL last exactly 24 edges (T1..T24); at counter=23 the next state SHALL be NORM.
REQ-015: NORM at T25 SHALL register result, pulse done=1 and drop busy, and go to IDLE; end-to-end latency is 25 edges after T0.
REQ-016: A start at T25's following cycle SHALL be accepted (back-to-back, 26-cycle throughput).
REQ-017: Mantissas SHALL be {1,frac} for exponent 1..254; exponent 0 inputs SHALL be treated as zero (denormals flushed).
REQ-018: Sign SHALL be a[31] XOR b[31] for every result, including zero and inf.
REQ-019: The exponent SHALL be computed as ea+eb-127 in 10-bit signed arithmetic.
REQ-020: Normalisation SHALL follow product bit 47.
- If bit 47 is 1: fraction = prod[46:24] and exponent +1.
- Else: fraction = prod[45:23].
- Rounding is truncation.
REQ-021: A normalised exponent >=255 SHALL give signed infinity {s,8'hFF,23'h0}.
REQ-022: A normalised exponent <=0 SHALL give signed zero.
REQ-023: Either operand NaN, or inf x zero, SHALL give 32'h7FC00000.
REQ-024: inf x nonzero-finite or inf x inf SHALL give signed infinity.
REQ-025: zero x finite SHALL give signed zero.
REQ-026: Special cases SHALL still take the full 25-edge latency (fixed latency).

Reset
REQ-027: rst=1 at any edge SHALL force IDLE, busy=0, done=0, result=32'h0, and clear counter, accumulator and latched operands.
REQ-028: Reset SHALL take effect even mid-MULT or in NORM; the aborted operation SHALL produce no done.
REQ-029: Reset SHALL override a simultaneous start.

Structure
REQ-030: Shared package fmult_pkg SHALL hold the following, for reuse by the adder and multiplier.
- State enum.
- BIAS=127.
- EXP_MAX=255.
- QNAN=32'h7FC00000.
- MANT_W=24.
- STEPS=24.
REQ-031: The datapath SHALL be one sub-module, fmult_shift_add, which holds the accumulator, multiplier shift register and step counter, with load/step controls and a last_step flag.
REQ-032: The FSM, exponent/sign logic, special-case decode and normalisation SHALL live in fmult_iter.

Verification
REQ-033: 0x3FC00000 x 0x40000000 -> result 0x40400000, done at edge T25, busy high for T0..T24.
REQ-034: 0x40400000 x 0xBF000000 -> 0xBFC00000; 0x80000000 x 0x3F800000 -> 0x80000000.
REQ-035: 0x7F000000 x 0x7F000000 -> 0x7F800000 (overflow); 0x00800000 x 0x00800000 -> 0x00000000 (underflow).
REQ-036: 0x7F800000 x 0x00000000 -> 0x7FC00000; 0x7FC00001 x 0x3F800000 -> 0x7FC00000.
REQ-037: start re-pulsed at T5 with new operands -> ignored, first result unchanged; start in the cycle after done -> accepted.
REQ-038: rst at T10 -> busy=0 next cycle, no done, result=0; a new start then completes normally after 25 edges.
